// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, state type and helpers
// for the pwm duty scheduler slice.
package pwm_pkg;

  localparam int DEF_CNT_W = 10;
  localparam int DEF_PRE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } state_t;

  function automatic int period_last(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int PERIOD_LAST = period_last(DEF_CNT_W);

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running divider that strobes
// tick once every limit+1 enabled clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] limit,
  output logic             tick
);

  logic [PRE_W-1:0] count;

  assign tick = en & (count == limit);

  // count 0..limit while enabled, wrap on tick
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: fetches duty samples, double
// buffers them and commits on pwm period boundaries.
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_req,
  output logic             pwm_tick,
  output logic [CNT_W-1:0] duty_out,
  output logic             period_start,
  output logic             underrun,
  input  logic             underrun_clr,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(period_last(CNT_W));

  state_t           state;
  state_t           state_nxt;
  logic [PRE_W-1:0] pre_lat;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] shadow;
  logic             shadow_full;
  logic             running;
  logic             xfer;
  logic             bnd;
  logic             load_pre;
  logic             start;
  logic             under_set;

  assign running = (state == RUN) ||
                   (state == DRAIN);
  assign xfer = sample_req & sample_valid;
  assign bnd = pwm_tick & (phase == LAST);
  assign period_start =
    pwm_tick & (phase == '0);
  assign busy = (state != IDLE);
  assign under_set =
    bnd & ~shadow_full & ~xfer;

  pwm_prescaler #(
    .PRE_W(PRE_W)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (running),
    .clr  (start),
    .limit(pre_lat),
    .tick (pwm_tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, sample request, control strobes
  always_comb begin
    state_nxt  = state;
    sample_req = 1'b0;
    load_pre   = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          load_pre  = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        sample_req = 1'b1;
        if (sample_valid) begin
          start     = 1'b1;
          state_nxt = RUN;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        sample_req = ~shadow_full;
        if (!enable) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bnd) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // prescale latch, phase, shadow and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_lat     <= '0;
      phase       <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      duty_out    <= '0;
    end else begin
      if (load_pre) begin
        pre_lat <= prescale;
      end
      if (start) begin
        duty_out    <= sample_in;
        phase       <= '0;
        shadow_full <= 1'b0;
      end else if (pwm_tick) begin
        phase <= phase + 1'b1;
      end
      if (bnd) begin
        if (shadow_full) begin
          duty_out    <= shadow;
          shadow_full <= 1'b0;
        end else if (xfer) begin
          duty_out <= sample_in;
        end
      end else if (xfer && state == RUN) begin
        shadow      <= sample_in;
        shadow_full <= 1'b1;
      end
    end
  end

  // sticky underrun, set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (under_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// tb_pwm_duty_scheduler: random and directed stimulus
// against a tick/period level reference model.
module tb_pwm_duty_scheduler;

  localparam int CW = 4;
  localparam int PW = 16;
  localparam int NPH = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [CW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_req;
  logic          pwm_tick;
  logic [CW-1:0] duty_out;
  logic          period_start;
  logic          underrun;
  logic          underrun_clr;
  logic          busy;

  always #5 clk = ~clk;

  pwm_duty_scheduler #(
    .CNT_W(CW),
    .PRE_W(PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .prescale    (prescale),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_req  (sample_req),
    .pwm_tick    (pwm_tick),
    .duty_out    (duty_out),
    .period_start(period_start),
    .underrun    (underrun),
    .underrun_clr(underrun_clr),
    .busy        (busy)
  );

  typedef struct {
    int c;
    int duty;
    bit ps;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 0;

  // model: mode 0 idle, 1 prime, 2 run, 3 drain
  int m_mode = 0;
  int m_pre = 0;
  int m_age = 0;
  int m_duty = 0;
  bit m_under = 0;
  int m_pend[$];
  bit last_tick = 0;
  int last_ph = 0;

  bit g_en = 0;
  int g_pre = 0;
  bit g_clr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               n, act, exp, cyc);
    end
  endtask

  function automatic bit m_tick();
    return (m_mode >= 2) &&
           ((m_age + 1) % (m_pre + 1) == 0);
  endfunction

  function automatic int m_idx();
    return ((m_age + 1) / (m_pre + 1) - 1) % NPH;
  endfunction

  task automatic step();
    bit req, xfer, tk, bnd, set;
    int ph;
    set = 0;
    req = (m_mode == 1) ||
          (m_mode == 2 && m_pend.size() == 0);
    xfer = req && sample_valid;
    tk = m_tick();
    ph = m_idx();
    bnd = tk && (ph == NPH - 1);
    if (armed) begin
      chk("sample_req", sample_req, req);
      chk("pwm_tick", pwm_tick, tk);
      chk("busy", busy, m_mode != 0);
      chk("underrun", underrun, m_under);
      chk("duty_out", duty_out, m_duty);
      chk("period_start", period_start,
          tk && ph == 0);
      if (tk) sbq.push_back('{cyc, m_duty, ph == 0});
    end
    last_tick = tk;
    last_ph = ph;
    case (m_mode)
      0: begin
        if (enable) begin
          m_pre = int'(prescale);
          m_mode = 1;
        end
      end
      1: begin
        if (sample_valid) begin
          m_duty = int'(sample_in);
          m_age = 0;
          m_pend.delete();
          m_mode = 2;
        end else if (!enable) begin
          m_mode = 0;
        end
      end
      default: begin
        m_age++;
        if (bnd) begin
          if (m_pend.size() > 0)
            m_duty = m_pend.pop_front();
          else if (xfer)
            m_duty = int'(sample_in);
          else
            set = 1;
        end else if (xfer) begin
          m_pend.push_back(int'(sample_in));
        end
        if (m_mode == 2 && !enable)
          m_mode = 3;
        else if (m_mode == 3 && bnd)
          m_mode = 0;
      end
    endcase
    if (set) m_under = 1;
    else if (underrun_clr) m_under = 0;
    if (reset) begin
      m_mode = 0;
      m_pre = 0;
      m_age = 0;
      m_duty = 0;
      m_under = 0;
      m_pend.delete();
      armed = 1;
    end
  endtask

  task automatic clk1(input bit rst, input bit en,
                      input int pre, input bit val,
                      input int din, input bit clr);
    @(posedge clk);
    #1;
    reset = rst;
    enable = en;
    prescale = PW'(pre);
    sample_valid = val;
    sample_in = CW'(din);
    underrun_clr = clr;
    #1;
    step();
  endtask

  // pol: 0 random, 1 always, 2 never, 3 on boundary
  task automatic run(input int n, input int pol);
    for (int i = 0; i < n; i++) begin
      bit v;
      case (pol)
        0: v = 1'($urandom_range(0, 1));
        1: v = 1;
        2: v = 0;
        default: v = m_tick() && m_idx() == NPH - 1;
      endcase
      clk1(0, g_en, g_pre, v,
           int'($urandom_range(0, NPH - 1)), g_clr);
    end
  endtask

  task automatic wait_idle(input int pol);
    int n;
    n = 0;
    while (m_mode != 0 && n < 400) begin
      run(1, pol);
      n++;
    end
    chk("idle_reached", m_mode != 0, 0);
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    last_tick = 0;
    while (!(last_tick && last_ph == ph) && n < 400) begin
      run(1, 1);
      n++;
    end
    chk("phase_reached", n >= 400, 0);
  endtask

  // scoreboard monitor: one record per tick
  always @(negedge clk) begin
    if (armed && pwm_tick === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_tick: got tick want none cyc %0d",
                 cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_cycle", cyc, mon_e.c);
        chk("sb_duty", duty_out, mon_e.duty);
        chk("sb_pstart", period_start, mon_e.ps);
      end
    end
  end

  initial begin
    reset = 0;
    enable = 0;
    prescale = 0;
    sample_in = 0;
    sample_valid = 0;
    underrun_clr = 0;
    clk1(1, 0, 0, 0, 0, 0);
    clk1(1, 0, 0, 0, 0, 0);
    g_en = 1;
    g_pre = 3;
    run(2, 2);
    run(150, 1);
    g_en = 0;
    wait_idle(1);
    g_en = 1;
    g_pre = 0;
    run(60, 1);
    run(40, 2);
    g_clr = 1;
    run(1, 2);
    g_clr = 0;
    run(50, 3);
    run(20, 1);
    wait_phase(5);
    g_en = 0;
    wait_idle(1);
    run(30, 0);
    g_en = 1;
    run(5, 1);
    wait_phase(7);
    clk1(1, 1, 0, 1, 5, 0);
    run(60, 1);
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      if ($urandom_range(0, 119) == 0) g_en = !g_en;
      g_pre = int'($urandom_range(0, 3));
      g_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 799) == 0);
      clk1(rst, g_en, g_pre,
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, NPH - 1)), g_clr);
    end
    g_clr = 0;
    g_en = 0;
    wait_idle(0);
    run(5, 0);
    chk("sb_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
